// File: rtl/pipe_hazard_tracker.sv
// rtl/pipe_hazard_tracker.sv - PC and D/X, X/M destination tracking for the hazard unit
//
// Producer side of the hazard-unit interface. Owns the fetch PC, the F/D valid
// bit and the D/X and X/M destination-tracking latches. It drives ex_dest,
// ex_rfWEN, mem_dest, mem_rfWEN and a gated ihit to the hazard unit, and
// consumes fdEN, pcEN and dx_flush back from it. A small RUN/DWAIT/HALT FSM
// freezes the pipeline on data-memory misses and after a HALT retires.
//
// Ports:
//   CLK, RST          clock (rising edge), asynchronous active-high reset
//   ihit_in, dhit     instruction / data memory hit this cycle
//   fdEN, pcEN        hazard unit: F/D latch enable, PC enable
//   dx_flush          hazard unit: insert bubble into D/X
//   dec_dest/rfWEN    decode-stage destination register and write enable
//   dec_mem, dec_halt decode-stage instruction is load/store, is HALT
//   br_taken/target   EX-stage redirect request and target
//   pc                current fetch PC
//   ihit              ihit_in gated low while frozen or halted
//   fd_valid          F/D latch holds a real instruction
//   ex_dest/rfWEN     D/X destination tracking
//   mem_dest/rfWEN    X/M destination tracking
//   mem_access        X/M instruction is load/store
//   halt              pipeline halted, sticky until reset
module pipe_hazard_tracker #(
  parameter logic [31:0] PC_INIT = 32'h0,
  parameter int          REG_W   = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit_in,
  input  logic             dhit,
  input  logic             fdEN,
  input  logic             pcEN,
  input  logic             dx_flush,
  input  logic [REG_W-1:0] dec_dest,
  input  logic             dec_rfWEN,
  input  logic             dec_mem,
  input  logic             dec_halt,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  output logic [31:0]      pc,
  output logic             ihit,
  output logic             fd_valid,
  output logic [REG_W-1:0] ex_dest,
  output logic             ex_rfWEN,
  output logic [REG_W-1:0] mem_dest,
  output logic             mem_rfWEN,
  output logic             mem_access,
  output logic             halt
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state;

  // D/X and X/M side bits that are not exported directly
  logic ex_mem;
  logic ex_halt;
  logic mem_halt;

  logic freeze;
  logic dx_bubble;

  // Freeze reacts in the same cycle the miss is visible in X/M, so nothing
  // downstream of the memory stage ever advances past an outstanding access.
  assign freeze    = (mem_access & ~dhit) | (state == ST_HALT);
  assign ihit      = ihit_in & ~freeze;
  assign dx_bubble = dx_flush | br_taken | ~fd_valid;

  // Control FSM; halt is registered alongside the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= ST_RUN;
      halt  <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (mem_halt & (~mem_access | dhit)) begin
            state <= ST_HALT;
            halt  <= 1'b1;
          end else if (mem_access & ~dhit) begin
            state <= ST_DWAIT;
          end
        end
        ST_DWAIT: begin
          if (mem_halt & dhit) begin
            state <= ST_HALT;
            halt  <= 1'b1;
          end else if (dhit) begin
            state <= ST_RUN;
          end
        end
        ST_HALT: begin
          state <= ST_HALT;
          halt  <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
          halt  <= 1'b0;
        end
      endcase
    end
  end

  // PC and F/D valid
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc       <= PC_INIT;
      fd_valid <= 1'b0;
    end else if (!freeze) begin
      // A resolved redirect wins over pcEN and does not need an ihit.
      if (br_taken) begin
        pc <= br_target;
      end else if (pcEN && ihit) begin
        pc <= pc + 32'd4;
      end

      if (br_taken) begin
        fd_valid <= 1'b0;
      end else if (fdEN) begin
        fd_valid <= ihit;
      end
    end
  end

  // D/X and X/M tracking latches
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ex_dest    <= '0;
      ex_rfWEN   <= 1'b0;
      ex_mem     <= 1'b0;
      ex_halt    <= 1'b0;
      mem_dest   <= '0;
      mem_rfWEN  <= 1'b0;
      mem_access <= 1'b0;
      mem_halt   <= 1'b0;
    end else if (!freeze) begin
      if (dx_bubble) begin
        ex_dest  <= '0;
        ex_rfWEN <= 1'b0;
        ex_mem   <= 1'b0;
        ex_halt  <= 1'b0;
      end else begin
        ex_dest  <= dec_dest;
        // r0 is hard-wired zero, so writes to it can never cause a hazard.
        ex_rfWEN <= dec_rfWEN & (dec_dest != '0);
        ex_mem   <= dec_mem;
        ex_halt  <= dec_halt;
      end

      mem_dest   <= ex_dest;
      mem_rfWEN  <= ex_rfWEN;
      mem_access <= ex_mem;
      mem_halt   <= ex_halt;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb/tb_pipe_hazard_tracker.sv - directed self-checking bench for pipe_hazard_tracker
module tb_pipe_hazard_tracker;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ihit_in, dhit, fdEN, pcEN, dx_flush;
  logic [4:0]  dec_dest;
  logic        dec_rfWEN, dec_mem, dec_halt, br_taken;
  logic [31:0] br_target;
  logic [31:0] pc;
  logic        ihit, fd_valid, ex_rfWEN, mem_rfWEN, mem_access, halt;
  logic [4:0]  ex_dest, mem_dest;

  int n_checks = 0;
  int n_errors = 0;

  pipe_hazard_tracker #(.PC_INIT(32'h0), .REG_W(5)) dut (
    .CLK(CLK), .RST(RST), .ihit_in(ihit_in), .dhit(dhit), .fdEN(fdEN),
    .pcEN(pcEN), .dx_flush(dx_flush), .dec_dest(dec_dest), .dec_rfWEN(dec_rfWEN),
    .dec_mem(dec_mem), .dec_halt(dec_halt), .br_taken(br_taken), .br_target(br_target),
    .pc(pc), .ihit(ihit), .fd_valid(fd_valid), .ex_dest(ex_dest), .ex_rfWEN(ex_rfWEN),
    .mem_dest(mem_dest), .mem_rfWEN(mem_rfWEN), .mem_access(mem_access), .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    ihit_in = 0; dhit = 0; fdEN = 0; pcEN = 0; dx_flush = 0;
    dec_dest = '0; dec_rfWEN = 0; dec_mem = 0; dec_halt = 0;
    br_taken = 0; br_target = '0;
    tick(); tick();
    RST = 1'b0;

    // reset state
    check("rst_pc", pc, 32'h0);
    check("rst_fd_valid", fd_valid, 0);
    check("rst_ex_rfWEN", ex_rfWEN, 0);
    check("rst_mem_rfWEN", mem_rfWEN, 0);
    check("rst_halt", halt, 0);

    // streaming: first slot is a bubble since F/D starts empty
    pcEN = 1; fdEN = 1; ihit_in = 1; dhit = 1; dec_dest = 5; dec_rfWEN = 1;
    tick();
    check("s1_pc", pc, 32'h4);
    check("s1_fd_valid", fd_valid, 1);
    check("s1_ex_rfWEN", ex_rfWEN, 0);
    tick();
    check("s2_pc", pc, 32'h8);
    check("s2_ex_dest", ex_dest, 5);
    check("s2_ex_rfWEN", ex_rfWEN, 1);
    check("s2_mem_rfWEN", mem_rfWEN, 0);
    tick();
    check("s3_pc", pc, 32'hC);
    check("s3_mem_dest", mem_dest, 5);
    check("s3_mem_rfWEN", mem_rfWEN, 1);

    // load travels to X/M, then data memory misses for 3 cycles
    dec_mem = 1; dec_dest = 3;
    tick();
    check("ld_ex_dest", ex_dest, 3);
    check("ld_pc", pc, 32'h10);
    dec_mem = 0; dec_dest = 6; dhit = 0;
    tick();
    check("ld_mem_access", mem_access, 1);
    check("ld_mem_dest", mem_dest, 3);
    check("ld_pc2", pc, 32'h14);
    check("miss_ihit", ihit, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("miss_pc", pc, 32'h14);
      check("miss_ex_dest", ex_dest, 6);
      check("miss_mem_dest", mem_dest, 3);
      check("miss_ihit_hold", ihit, 0);
    end
    dhit = 1;
    #1;
    check("hit_ihit", ihit, 1);
    tick();
    check("resume_pc", pc, 32'h18);
    check("resume_mem_dest", mem_dest, 6);
    check("resume_mem_access", mem_access, 0);

    // dx_flush with fdEN=0, pcEN=0
    dx_flush = 1; fdEN = 0; pcEN = 0;
    tick();
    check("flush_ex_rfWEN", ex_rfWEN, 0);
    check("flush_ex_dest", ex_dest, 0);
    check("flush_pc", pc, 32'h18);
    check("flush_fd_valid", fd_valid, 1);

    // branch redirect with pcEN=0
    dx_flush = 0; br_taken = 1; br_target = 32'h100;
    tick();
    check("br_pc", pc, 32'h100);
    check("br_fd_valid", fd_valid, 0);
    check("br_ex_rfWEN", ex_rfWEN, 0);
    br_taken = 0; pcEN = 1; fdEN = 1;
    tick();
    check("br2_pc", pc, 32'h104);
    check("br2_fd_valid", fd_valid, 1);
    check("br2_ex_rfWEN", ex_rfWEN, 0);

    // PC wrap
    br_taken = 1; br_target = 32'hFFFF_FFFC;
    tick();
    check("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    br_taken = 0;
    tick();
    check("wrap_pc", pc, 32'h0);

    // r0 destination never raises ex_rfWEN
    dec_dest = 0; dec_rfWEN = 1;
    tick();
    check("r0_ex_rfWEN", ex_rfWEN, 0);
    dec_dest = 9;
    tick();
    check("r9_ex_rfWEN", ex_rfWEN, 1);
    check("r9_ex_dest", ex_dest, 9);

    // HALT through D/X, X/M, then sticky freeze
    dec_halt = 1; dec_dest = 0;
    tick();
    check("h1_pc", pc, 32'hC);
    dec_halt = 0;
    tick();
    check("h2_halt", halt, 0);
    check("h2_pc", pc, 32'h10);
    tick();
    check("h3_halt", halt, 1);
    check("h3_pc", pc, 32'h14);
    check("h3_ihit", ihit, 0);
    tick(); tick();
    check("h5_halt", halt, 1);
    check("h5_pc", pc, 32'h14);

    // reset mid-run from pc=0x40
    RST = 1; tick(); RST = 0;
    br_taken = 1; br_target = 32'h40;
    tick();
    check("pre_rst_pc", pc, 32'h40);
    br_taken = 0; ihit_in = 0; pcEN = 0; fdEN = 0; dec_rfWEN = 0;
    #2;
    RST = 1;
    #1;
    check("async_rst_pc", pc, 32'h0);
    check("async_rst_fd_valid", fd_valid, 0);
    check("async_rst_ex_rfWEN", ex_rfWEN, 0);
    check("async_rst_mem_rfWEN", mem_rfWEN, 0);
    check("async_rst_halt", halt, 0);
    check("async_rst_ihit", ihit, 0);
    tick();
    RST = 0;
    tick();
    check("post_rst_pc", pc, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
